// File: rtl/can_bit_destuffer.sv
// CAN bit destuffer: removes dynamic and FD fixed stuff bits from the sampled
// bus stream, flags stuff errors, counts removed dynamic stuff bits and
// performs bus integration (bus-idle detection) ahead of the frame maker.
module can_bit_destuffer #(
   parameter int STUFF_LEN  = 5,
   parameter int IDLE_BITS  = 11,
   parameter int FIX_PERIOD = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       SMP_EN,
   input  logic       RX_S,
   input  logic       FD_CRC,
   input  logic       STF_OFF,
   output logic       SP,
   output logic       RX,
   output logic       F_STF,
   output logic [2:0] STF_CNT,
   output logic       BUS_IDLE
);

   localparam int REC_W = $clog2(IDLE_BITS + 1);
   localparam logic [REC_W-1:0] IDLE_MAX  = REC_W'(IDLE_BITS);
   localparam logic [2:0]       STUFF_MAX = 3'(STUFF_LEN);
   localparam logic [2:0]       FIX_MAX   = 3'(FIX_PERIOD);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACTIVE,
      S_FIXED,
      S_PASS,
      S_ERROR
   } state_t;

   state_t           state;
   logic [2:0]       run;
   logic [2:0]       pos;
   logic             last;
   logic [REC_W-1:0] rec_cnt;

   // Recessive-bit counter increment that saturates at the idle threshold
   function automatic logic [REC_W-1:0] rec_inc(input logic [REC_W-1:0] c);
      if (c >= IDLE_MAX) return IDLE_MAX;
      return c + 1'b1;
   endfunction

   // Destuffing state machine; every decision is taken on a sample strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         run      <= 3'd0;
         pos      <= 3'd0;
         last     <= 1'b0;
         rec_cnt  <= '0;
         SP       <= 1'b0;
         RX       <= 1'b1;
         F_STF    <= 1'b1;
         STF_CNT  <= 3'd0;
         BUS_IDLE <= 1'b0;
      end else begin
         SP <= 1'b0;
         if (SMP_EN) begin
            case (state)
               S_IDLE: begin
                  SP <= 1'b1;
                  RX <= RX_S;
                  if (RX_S) begin
                     rec_cnt <= rec_inc(rec_cnt);
                     if (rec_inc(rec_cnt) == IDLE_MAX) BUS_IDLE <= 1'b1;
                  end else if (!BUS_IDLE) begin
                     rec_cnt <= '0;
                  end else begin
                     // Start of frame after a completed bus integration
                     state    <= S_ACTIVE;
                     run      <= 3'd1;
                     last     <= 1'b0;
                     STF_CNT  <= 3'd0;
                     BUS_IDLE <= 1'b0;
                     rec_cnt  <= '0;
                  end
               end
               S_ACTIVE: begin
                  if (STF_OFF) begin
                     SP    <= 1'b1;
                     RX    <= RX_S;
                     state <= S_PASS;
                  end else if (FD_CRC) begin
                     // First CRC bit is the fixed stuff bit at position 0
                     if (RX_S == last) begin
                        F_STF   <= 1'b0;
                        rec_cnt <= '0;
                        state   <= S_ERROR;
                     end else begin
                        last  <= RX_S;
                        pos   <= (FIX_MAX == 3'd0) ? 3'd0 : 3'd1;
                        state <= S_FIXED;
                     end
                  end else if (run == STUFF_MAX) begin
                     if (RX_S != last) begin
                        STF_CNT <= STF_CNT + 3'd1;
                        last    <= RX_S;
                        run     <= 3'd1;
                     end else begin
                        F_STF   <= 1'b0;
                        rec_cnt <= '0;
                        state   <= S_ERROR;
                     end
                  end else begin
                     SP <= 1'b1;
                     RX <= RX_S;
                     if (RX_S == last) begin
                        run <= run + 3'd1;
                     end else begin
                        run  <= 3'd1;
                        last <= RX_S;
                     end
                  end
               end
               S_FIXED: begin
                  if (STF_OFF) begin
                     SP    <= 1'b1;
                     RX    <= RX_S;
                     state <= S_PASS;
                  end else if (pos == 3'd0) begin
                     if (RX_S == last) begin
                        F_STF   <= 1'b0;
                        rec_cnt <= '0;
                        state   <= S_ERROR;
                     end else begin
                        last <= RX_S;
                        pos  <= (FIX_MAX == 3'd0) ? 3'd0 : 3'd1;
                     end
                  end else begin
                     SP   <= 1'b1;
                     RX   <= RX_S;
                     last <= RX_S;
                     pos  <= (pos == FIX_MAX) ? 3'd0 : pos + 3'd1;
                  end
               end
               S_PASS: begin
                  SP <= 1'b1;
                  RX <= RX_S;
                  if (!STF_OFF) begin
                     state    <= S_IDLE;
                     rec_cnt  <= RX_S ? REC_W'(1) : '0;
                     BUS_IDLE <= 1'b0;
                  end
               end
               S_ERROR: begin
                  if (RX_S) begin
                     rec_cnt <= rec_inc(rec_cnt);
                     if (rec_inc(rec_cnt) == IDLE_MAX) begin
                        F_STF    <= 1'b1;
                        BUS_IDLE <= 1'b1;
                        state    <= S_IDLE;
                     end
                  end else begin
                     rec_cnt <= '0;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/can_bit_destuffer.md
Name: can_bit_destuffer

Overview:
Upstream neighbour of the CAN frame-maker FSM. Takes the raw bit sampled by the bit-timing logic on each sample strobe and removes dynamic stuff bits (classic/FD arbitration and data fields) and fixed stuff bits (FD CRC field). It produces the destuffed bit stream and the sample-point strobe that the frame maker consumes. It also detects stuff errors, tracks the dynamic stuff count for FD, and performs bus integration (bus-idle detection).

Parameters:
STUFF_LEN, 5, number of equal consecutive bits after which a stuff bit follows.
IDLE_BITS, 11, number of consecutive recessive bits that declare the bus idle.
FIX_PERIOD, 4, CRC data bits between FD fixed stuff bits.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
SMP_EN  input  1  one-clk strobe: RX_S is valid this cycle; strobes are at least 2 clk apart.
RX_S  input  1  raw sampled bus bit (0 = dominant).
FD_CRC  input  1  level from frame maker: current bit belongs to the FD CRC field (fixed stuffing).
STF_OFF  input  1  level from frame maker: stuffing ended (CRC delimiter onward).
SP  output  1  one-clk strobe: RX holds a forwarded bit.
RX  output  1  destuffed bit, held until the next forwarded bit.
F_STF  output  1  stuff-error flag, active low.
STF_CNT  output  3  dynamic stuff bits removed in the current frame, mod 8.
BUS_IDLE  output  1  high once IDLE_BITS recessive bits have been seen in IDLE/ERROR.

Behaviour:
- Reset values: SP=0, RX=1, F_STF=1, STF_CNT=0, BUS_IDLE=0. State=IDLE; run length, last bit, fixed-position counter and recessive counter are all cleared. Reset overrides a coincident SMP_EN.
- All decisions happen only on SMP_EN cycles. Outputs are registered, so a forwarded bit appears on SP/RX 1 clk after its SMP_EN. SP is never high for 2 consecutive clk.
- FD_CRC and STF_OFF are sampled in the SMP_EN cycle. If both are high, STF_OFF wins.
- States: IDLE, ACTIVE, FIXED, PASS, ERROR.
- IDLE:
  - Every bit is forwarded.
  - Recessive bit: increments the recessive counter, saturating at IDLE_BITS. BUS_IDLE=1 when the counter reaches IDLE_BITS.
  - Dominant bit with BUS_IDLE=0: counter and BUS_IDLE cleared; remain in IDLE.
  - Dominant bit with BUS_IDLE=1 (SOF): forwarded; go to ACTIVE with run=1, last=0, STF_CNT=0; BUS_IDLE cleared.
- ACTIVE:
  - STF_OFF=1: forward the bit, go to PASS.
  - FD_CRC=1: treat the bit as a fixed stuff bit at position 0 (FIXED rules below); go to FIXED.
  - run==STUFF_LEN and bit!=last: this is a stuff bit. It is not forwarded; STF_CNT+1 (wraps 7->0); last=bit; run=1.
  - run==STUFF_LEN and bit==last: stuff error. Not forwarded; F_STF=0; go to ERROR.
  - Otherwise: forward the bit. If bit==last, run+1; else run=1 and last=bit.
- FIXED:
  - Position counter pos runs 0..FIX_PERIOD and wraps to 0. Position 0 is the fixed stuff bit.
  - Position 0: bit must equal ~last; it is dropped and STF_CNT is unchanged. If bit==last: F_STF=0; go to ERROR.
  - Positions 1..FIX_PERIOD: forwarded. No dynamic stuff check, so runs longer than 5 are legal. last is updated on every bit.
  - STF_OFF=1: forward the bit; go to PASS. This takes priority over the position rule.
- PASS: every bit is forwarded unchanged. When STF_OFF=0 on an SMP_EN, go to IDLE with the recessive counter=1 if the bit is recessive, else 0, and BUS_IDLE=0. That bit is forwarded.
- ERROR:
  - No SP pulses; F_STF held 0.
  - Recessive counter runs as in IDLE; a dominant bit clears it.
  - When the counter reaches IDLE_BITS: F_STF=1, BUS_IDLE=1, go to IDLE.
- Run and pos counters are 3 bits; pos never exceeds FIX_PERIOD.

Test Plan:
- Reset, then 10 recessive SMP_EN -> BUS_IDLE=0. 11th recessive -> BUS_IDLE=1 one clk later. 10 SP pulses with RX=1 so far, 11 in total.
- From idle, send bits 0,0,0,0,0,1,0 -> SP pulses only for the SOF and the four following 0s, plus the final 0. The 1 is dropped; STF_CNT=1; F_STF=1.
- From idle, send 6 dominant bits -> 5 SP pulses; no SP for the 6th; F_STF=0 one clk after the 6th. Then 11 recessive -> F_STF=1, BUS_IDLE=1, no SP during ERROR.
- In ACTIVE with last=1, raise FD_CRC. Send 0,1,1,1,1,0,0,0,0,0 -> first 0 and the 0 at position 0 of the second group are dropped; 8 bits forwarded; STF_CNT unchanged; F_STF=1. Repeat with a fixed bit equal to last -> F_STF=0.
- In ACTIVE, raise STF_OFF and send 1,0,1,1,1,1,1,1 -> all 8 forwarded. Drop STF_OFF -> IDLE; a further 11 recessive -> BUS_IDLE=1.
- Assert reset mid-frame in ACTIVE with run=4 and STF_CNT=3 -> next clk: SP=0, RX=1, F_STF=1, STF_CNT=0, BUS_IDLE=0. A following dominant bit does not start a frame.
